somador2comp: RTL and testbench
===============================

Name: somador2comp

Overview:
- Multi-cycle signed adder for two N-bit two's-complement operands, built as a control unit (FSM) driving a datapath.
- The sum is computed in sign-magnitude form: operands are converted to magnitudes, magnitudes and signs are compared, then magnitudes are added or subtracted.
- The N+1-bit two's-complement result is registered.
- Standalone arithmetic block started by a level start signal. Per-step control strobes are exported for observability.

Parameters:
- N, 5, operand width in bits (two's complement); N >= 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- S  input  1  start request, level-sensitive, sampled only in IDLE.
- a  input  N  operand A, two's complement.
- b  input  N  operand B, two's complement.
- result  output  N+1  registered sum A+B, two's complement.
- loadAB  output  1  strobe: capture a, b and their sign bits.
- loadmagAB  output  1  strobe: capture magnitudes of A and B.
- compmag  output  1  strobe: compare magnitudes.
- compsigns  output  1  strobe: compare signs.
- add_sub  output  1  strobe: add or subtract magnitudes.
- loadres  output  1  strobe: capture the final result.
- done  output  1  operation complete, high for one cycle.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, RESET).
- Reset (RESET=1 at a rising edge):
  - FSM goes to IDLE.
  - All datapath registers and result are cleared to 0.
  - All strobes and done are 0.
  - Reset overrides every other input; asserted mid-operation, it aborts the operation.
- FSM is Moore type; exactly one strobe is high per state (none in IDLE).
- States and transitions:
  - IDLE: if S=1 go to LOAD_AB, else stay.
  - LOAD_AB (loadAB=1): on the edge, A<=a, B<=b, sA<=a[N-1], sB<=b[N-1].
  - LOAD_MAG (loadmagAB=1): mA<=|A|, mB<=|B|, each N-bit unsigned (-2^(N-1) gives 2^(N-1)).
  - COMP_MAG (compmag=1): register gtA = (mA >= mB).
  - COMP_SIGNS (compsigns=1): register same = (sA == sB).
  - ADD_SUB (add_sub=1):
    - If same: M <= mA+mB (N+1 bits), sR <= sA.
    - Else: M <= larger - smaller, sR <= sign of the larger-magnitude operand.
    - If mA==mB with differing signs: M=0, sR=0 (no negative zero).
  - LOAD_RES (loadres=1): result <= sR ? -M : M, in N+1-bit two's complement.
  - DONE (done=1), then unconditionally go to IDLE.
- Latency:
  - Start accepted at edge k; result updates at edge k+6; done is high during cycle k+6..k+7.
  - Earliest restart is edge k+8 (IDLE sees S).
  - With S held high, operations repeat back-to-back, one every 8 cycles.
- Operands: sampled only at the end of LOAD_AB. Changes on a/b at any other time do not affect the operation in progress.
- result holds its value between operations. It changes only at LOAD_RES or on reset.
- Overflow is impossible: N+1 bits covers the range -2^N .. 2^N-2.
- S has no effect outside IDLE; deasserting S mid-operation does not abort.

Test Plan:
- Reset, then S=1, a=3, b=-8 (N=5) -> at edge k+6, result=6'b111011 (-5); done pulses one cycle; strobes appear in order loadAB, loadmagAB, compmag, compsigns, add_sub, loadres.
- a=-16, b=-16 -> result=6'b100000 (-32); a=15, b=15 -> result=6'b011110 (30).
- a=5, b=-5 -> result=0 (sign bit 0); a=-3, b=7 -> result=4; a=-7, b=2 -> result=-5 (111011).
- S=0 after reset -> FSM stays IDLE, all strobes 0, result remains 0; S held high -> done pulses every 8 cycles, and a new a/b applied mid-operation only appears in the next result.
- RESET asserted during ADD_SUB -> next cycle FSM in IDLE, result=0, no done pulse; operation restarts cleanly when S=1.

Source files
------------

// File: rtl/somador2comp.sv
// somador2comp: multi-cycle signed adder for two N-bit two's-complement
// operands. The FSM walks the datapath through sign-magnitude conversion,
// magnitude/sign comparison and add/subtract, then registers the N+1-bit
// two's-complement sum.
//
// Ports:
//   clk        system clock, rising edge
//   RESET      synchronous, active-high reset
//   S          start request (level, sampled only in IDLE)
//   a, b       N-bit two's-complement operands
//   result     registered N+1-bit two's-complement sum
//   loadAB, loadmagAB, compmag, compsigns, add_sub, loadres
//              per-step control strobes, one per state
//   done       one-cycle completion pulse
//
// state      | meaning
// -----------+----------------------------------------------
// IDLE       | waiting for S
// LOAD_AB    | capture a, b and their sign bits
// LOAD_MAG   | capture magnitudes |A|, |B|
// COMP_MAG   | register mA >= mB
// COMP_SIGNS | register sA == sB
// ADD_SUB    | add or subtract magnitudes, pick result sign
// LOAD_RES   | convert sign-magnitude to two's complement
// DONE       | completion pulse, back to IDLE

module somador2comp #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         S,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   result,
    output logic         loadAB,
    output logic         loadmagAB,
    output logic         compmag,
    output logic         compsigns,
    output logic         add_sub,
    output logic         loadres,
    output logic         done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_AB,
        ST_LOAD_MAG,
        ST_COMP_MAG,
        ST_COMP_SIGNS,
        ST_ADD_SUB,
        ST_LOAD_RES,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0] a_q, b_q;
    logic         sa_q, sb_q;
    logic [N-1:0] ma_q, mb_q;
    logic         gta_q, same_q;
    logic [N:0]   m_q;
    logic         sr_q;

    logic [N-1:0] ma_d, mb_d;
    logic [N:0]   m_d;
    logic         sr_d;
    logic [N:0]   res_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (S) state_d = ST_LOAD_AB;
            ST_LOAD_AB:    state_d = ST_LOAD_MAG;
            ST_LOAD_MAG:   state_d = ST_COMP_MAG;
            ST_COMP_MAG:   state_d = ST_COMP_SIGNS;
            ST_COMP_SIGNS: state_d = ST_ADD_SUB;
            ST_ADD_SUB:    state_d = ST_LOAD_RES;
            ST_LOAD_RES:   state_d = ST_DONE;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each one is high
    // exactly while the FSM sits in its state, with no decode glitches.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            loadAB    <= 1'b0;
            loadmagAB <= 1'b0;
            compmag   <= 1'b0;
            compsigns <= 1'b0;
            add_sub   <= 1'b0;
            loadres   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            loadAB    <= (state_d == ST_LOAD_AB);
            loadmagAB <= (state_d == ST_LOAD_MAG);
            compmag   <= (state_d == ST_COMP_MAG);
            compsigns <= (state_d == ST_COMP_SIGNS);
            add_sub   <= (state_d == ST_ADD_SUB);
            loadres   <= (state_d == ST_LOAD_RES);
            done      <= (state_d == ST_DONE);
        end
    end

    // Magnitude as N-bit unsigned: the most negative value negates to
    // itself, which read unsigned is exactly 2^(N-1).
    always_comb begin
        ma_d = a_q[N-1] ? (~a_q + N'(1)) : a_q;
        mb_d = b_q[N-1] ? (~b_q + N'(1)) : b_q;
    end

    always_comb begin
        m_d  = '0;
        sr_d = 1'b0;
        if (same_q) begin
            m_d  = {1'b0, ma_q} + {1'b0, mb_q};
            sr_d = sa_q;
        end else if (gta_q) begin
            m_d  = {1'b0, ma_q} - {1'b0, mb_q};
            // equal magnitudes with opposite signs: force +0
            sr_d = (ma_q == mb_q) ? 1'b0 : sa_q;
        end else begin
            m_d  = {1'b0, mb_q} - {1'b0, ma_q};
            sr_d = sb_q;
        end
    end

    always_comb begin
        res_d = sr_q ? (~m_q + (N+1)'(1)) : m_q;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            a_q    <= '0;
            b_q    <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            ma_q   <= '0;
            mb_q   <= '0;
            gta_q  <= 1'b0;
            same_q <= 1'b0;
            m_q    <= '0;
            sr_q   <= 1'b0;
            result <= '0;
        end else begin
            case (state_q)
                ST_LOAD_AB: begin
                    a_q  <= a;
                    b_q  <= b;
                    sa_q <= a[N-1];
                    sb_q <= b[N-1];
                end
                ST_LOAD_MAG: begin
                    ma_q <= ma_d;
                    mb_q <= mb_d;
                end
                ST_COMP_MAG:   gta_q  <= (ma_q >= mb_q);
                ST_COMP_SIGNS: same_q <= (sa_q == sb_q);
                ST_ADD_SUB: begin
                    m_q  <= m_d;
                    sr_q <= sr_d;
                end
                ST_LOAD_RES:   result <= res_d;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_somador2comp.sv
module tb_somador2comp;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         RESET;
    logic         S;
    logic [N-1:0] a, b;
    logic [N:0]   result;
    logic         loadAB, loadmagAB, compmag, compsigns, add_sub, loadres, done;
    logic [6:0]   strobes;

    int checks = 0;
    int errors = 0;
    logic [N:0] prev_res;

    somador2comp #(.N(N)) dut (
        .clk(clk), .RESET(RESET), .S(S), .a(a), .b(b), .result(result),
        .loadAB(loadAB), .loadmagAB(loadmagAB), .compmag(compmag),
        .compsigns(compsigns), .add_sub(add_sub), .loadres(loadres),
        .done(done)
    );

    always #5 clk = ~clk;

    assign strobes = {done, loadres, add_sub, compsigns, compmag, loadmagAB, loadAB};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition, wrapped to N+1 bits.
    function automatic logic [N:0] model_sum(input int av, input int bv);
        int s;
        s = av + bv;
        return s[N:0];
    endfunction

    // Runs one operation starting from a negedge while the DUT is idle.
    // Step i (after edge k+i) must show only strobe i; operands are
    // scrambled once they have been captured.
    task automatic do_op(input int av, input int bv, input bit keep_s);
        logic [N:0] exp;
        logic [31:0] one_hot;
        exp = model_sum(av, bv);
        a = av[N-1:0];
        b = bv[N-1:0];
        S = 1'b1;
        for (int step = 0; step < 7; step++) begin
            @(negedge clk);
            if (step == 0 && !keep_s) S = 1'b0;
            if (step == 1) begin
                a = N'($urandom);
                b = N'($urandom);
            end
            one_hot = 32'd1 << step;
            check($sformatf("strobe_step%0d", step), {25'd0, strobes}, one_hot);
            if (step == 5) check("result_hold", {26'd0, result}, {26'd0, prev_res});
            if (step == 6) check($sformatf("result_%0d_plus_%0d", av, bv),
                                 {26'd0, result}, {26'd0, exp});
        end
        @(negedge clk);
        check("idle_after_done", {25'd0, strobes}, 32'd0);
        prev_res = exp;
    endtask

    initial begin
        RESET = 1'b1;
        S = 1'b0;
        a = '0;
        b = '0;
        prev_res = '0;
        repeat (2) @(negedge clk);
        check("reset_result", {26'd0, result}, 32'd0);
        check("reset_strobes", {25'd0, strobes}, 32'd0);
        RESET = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("idle_no_start_strobes", {25'd0, strobes}, 32'd0);
        end
        check("idle_no_start_result", {26'd0, result}, 32'd0);

        do_op(3, -8, 1'b0);
        do_op(-16, -16, 1'b0);
        do_op(15, 15, 1'b0);
        do_op(5, -5, 1'b0);
        do_op(-3, 7, 1'b0);
        do_op(-7, 2, 1'b0);

        // back-to-back with S held high
        do_op(9, -4, 1'b1);
        do_op(-16, 15, 1'b1);
        do_op(-1, -1, 1'b1);
        do_op(0, -16, 1'b0);

        // abort from ADD_SUB
        a = 5'd6;
        b = 5'd7;
        S = 1'b1;
        repeat (5) @(negedge clk);
        S = 1'b0;
        check("abort_in_add_sub", {31'd0, add_sub}, 32'd1);
        RESET = 1'b1;
        @(negedge clk);
        check("abort_strobes", {25'd0, strobes}, 32'd0);
        check("abort_result", {26'd0, result}, 32'd0);
        RESET = 1'b0;
        prev_res = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        do_op(-10, 4, 1'b0);

        for (int i = 0; i < 20; i++) begin
            int av, bv;
            av = int'($urandom_range(0, 31)) - 16;
            bv = int'($urandom_range(0, 31)) - 16;
            do_op(av, bv, bit'($urandom_range(0, 1)));
        end
        S = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
